// File: rtl/branch_predictor_bimodal.sv
// Bimodal branch predictor: direct-mapped BTB plus a PHT of 2-bit saturating counters.
// Next_PC is combinational from PC and current table state; tables are trained at the clock edge.
module branch_predictor_bimodal #(
    parameter logic [31:0] INVALID_PC             = 32'hfafafafa,
    parameter logic [31:0] KEEP_EXPECTING_PC_NEXT = 32'hbfbfbfbf,
    parameter int          BTB_ENTRIES            = 64,
    parameter int          PHT_ENTRIES            = 256,
    parameter logic [1:0]  PHT_INIT               = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] Next_PC,
    output logic        pred_taken,
    output logic        btb_hit,
    input  logic        update,
    input  logic [31:0] update_PC,
    input  logic        update_taken,
    input  logic [31:0] update_target
);
    localparam int BI = $clog2(BTB_ENTRIES);
    localparam int PI = $clog2(PHT_ENTRIES);
    localparam int TW = 30 - BI;

    logic          btb_valid  [BTB_ENTRIES];
    logic [TW-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]   btb_target [BTB_ENTRIES];
    logic [1:0]    pht        [PHT_ENTRIES];

    logic [BI-1:0] rd_btb_idx;
    logic [TW-1:0] rd_tag;
    logic [PI-1:0] rd_pht_idx;
    logic [BI-1:0] wr_btb_idx;
    logic [TW-1:0] wr_tag;
    logic [PI-1:0] wr_pht_idx;
    logic          train;
    logic          unused_low_bits;

    assign rd_btb_idx = PC[BI+1:2];
    assign rd_tag     = PC[31:BI+2];
    assign rd_pht_idx = PC[PI+1:2];
    assign wr_btb_idx = update_PC[BI+1:2];
    assign wr_tag     = update_PC[31:BI+2];
    assign wr_pht_idx = update_PC[PI+1:2];
    assign train      = update && (update_PC != INVALID_PC);

    // Instructions are word aligned, so the byte offset carries no information.
    assign unused_low_bits = ^{PC[1:0], update_PC[1:0]};

    always_comb begin
        Next_PC    = PC + 32'd4;
        pred_taken = 1'b0;
        btb_hit    = 1'b0;
        if (PC == INVALID_PC) begin
            Next_PC = KEEP_EXPECTING_PC_NEXT;
        end else begin
            btb_hit = btb_valid[rd_btb_idx] && (btb_tag[rd_btb_idx] == rd_tag);
            if (btb_hit && pht[rd_pht_idx][1]) begin
                Next_PC    = btb_target[rd_btb_idx];
                pred_taken = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
            for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= PHT_INIT;
        end else if (train) begin
            if (update_taken) begin
                btb_valid[wr_btb_idx] <= 1'b1;
                if (pht[wr_pht_idx] != 2'b11) pht[wr_pht_idx] <= pht[wr_pht_idx] + 2'd1;
            end else begin
                if (pht[wr_pht_idx] != 2'b00) pht[wr_pht_idx] <= pht[wr_pht_idx] - 2'd1;
            end
        end
    end

    // Tag and target need no reset: they are only observed through a valid entry.
    always_ff @(posedge clk) begin
        if (!rst && train && update_taken) begin
            btb_tag[wr_btb_idx]    <= wr_tag;
            btb_target[wr_btb_idx] <= update_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor_bimodal.sv
// Directed-vector bench for branch_predictor_bimodal with default parameters.
module tb_branch_predictor_bimodal;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic [31:0] Next_PC;
    logic        pred_taken;
    logic        btb_hit;
    logic        update;
    logic [31:0] update_PC;
    logic        update_taken;
    logic [31:0] update_target;

    int errors = 0;
    int checks = 0;

    branch_predictor_bimodal dut (
        .clk           (clk),
        .rst           (rst),
        .PC            (PC),
        .Next_PC       (Next_PC),
        .pred_taken    (pred_taken),
        .btb_hit       (btb_hit),
        .update        (update),
        .update_PC     (update_PC),
        .update_taken  (update_taken),
        .update_target (update_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic [31:0] exp_next, input logic exp_pt, input logic exp_hit);
        PC = pc;
        #1;
        check({tag, ".next"}, Next_PC, exp_next);
        check({tag, ".pt"}, {31'd0, pred_taken}, {31'd0, exp_pt});
        check({tag, ".hit"}, {31'd0, btb_hit}, {31'd0, exp_hit});
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        update        = 1'b1;
        update_PC     = pc;
        update_taken  = taken;
        update_target = tgt;
        @(posedge clk);
        #1;
        update = 1'b0;
    endtask

    initial begin
        rst = 1'b1; PC = 32'h0; update = 1'b0;
        update_PC = 32'h0; update_taken = 1'b0; update_target = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        look("rst_100", 32'h0000_0100, 32'h0000_0104, 1'b0, 1'b0);
        look("rst_bubble", 32'hfafa_fafa, 32'hbfbf_bfbf, 1'b0, 1'b0);

        // first taken update: same-cycle lookup sees old contents
        PC = 32'h100; update = 1'b1; update_PC = 32'h100;
        update_taken = 1'b1; update_target = 32'h200;
        #1;
        check("same_cycle.next", Next_PC, 32'h104);
        @(posedge clk);
        #1;
        update = 1'b0;
        look("trained1", 32'h100, 32'h200, 1'b1, 1'b1);

        // three more taken -> 11, then two not-taken -> 01
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        look("sat11", 32'h100, 32'h200, 1'b1, 1'b1);
        train(32'h100, 1'b0, 32'h0);
        look("nt_10", 32'h100, 32'h200, 1'b1, 1'b1);
        train(32'h100, 1'b0, 32'h0);
        look("nt_01", 32'h100, 32'h104, 1'b0, 1'b1);

        // down to 00 and saturate there; one taken -> 01, another -> 10
        train(32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b1, 32'h200);
        look("sat00_up01", 32'h100, 32'h104, 1'b0, 1'b1);
        train(32'h100, 1'b1, 32'h200);
        look("up10", 32'h100, 32'h200, 1'b1, 1'b1);

        // alias: 0x200 shares btb index 0 with 0x100 but has a different tag
        train(32'h200, 1'b1, 32'h300);
        look("alias_old", 32'h100, 32'h104, 1'b0, 1'b0);
        look("alias_new", 32'h200, 32'h300, 1'b1, 1'b1);

        // not-taken on a fresh PC moves only the counter, no BTB entry
        train(32'h340, 1'b0, 32'h999);
        look("nt_nobtb", 32'h340, 32'h344, 1'b0, 1'b0);

        // bubble update ignored: 0xfafafaf8 shares index and tag with the bubble PC
        train(32'hfafa_fafa, 1'b1, 32'h500);
        train(32'hfafa_fafa, 1'b1, 32'h500);
        look("bubble_upd", 32'hfafa_faf8, 32'hfafa_fafc, 1'b0, 1'b0);

        // reset dominates a simultaneous update
        rst = 1'b1; update = 1'b1; update_PC = 32'h200;
        update_taken = 1'b1; update_target = 32'h400;
        @(posedge clk);
        #1;
        rst = 1'b0; update = 1'b0;
        look("post_rst_200", 32'h200, 32'h204, 1'b0, 1'b0);
        look("post_rst_100", 32'h100, 32'h104, 1'b0, 1'b0);
        look("wrap", 32'hffff_fffc, 32'h0000_0000, 1'b0, 1'b0);
        look("post_rst_bubble", 32'hfafa_fafa, 32'hbfbf_bfbf, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_predictor_bimodal.md
Name: branch_predictor_bimodal

Overview:
- Parametrised successor to the fall-through predictor in the fetch stage.
- Adds a direct-mapped branch target buffer (BTB) and a pattern history table (PHT) of 2-bit saturating counters.
- Same-cycle combinational Next_PC for fetch.
- Trained by the execute stage on every resolved branch, with synchronous table writes.

Parameters:
- INVALID_PC, 32'hfafafafa, fetch bubble marker PC.
- KEEP_EXPECTING_PC_NEXT, 32'hbfbfbfbf, Next_PC returned for a bubble.
- BTB_ENTRIES, 64, BTB depth; power of two, ≥2.
- PHT_ENTRIES, 256, PHT depth; power of two, ≥2.
- PHT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- PC  in  32  fetch PC being predicted.
- Next_PC  out  32  predicted next fetch PC (combinational).
- pred_taken  out  1  1 when Next_PC came from the BTB target.
- btb_hit  out  1  valid entry with tag match for PC.
- update  in  1  a branch/jump resolved in execute this cycle (every resolution, not only mispredicts).
- update_PC  in  32  PC of the resolved branch instruction.
- update_taken  in  1  resolved direction.
- update_target  in  32  resolved taken target.

Behaviour:
- Indexing, with BI=log2(BTB_ENTRIES) and PI=log2(PHT_ENTRIES):
  - btb_idx = PC[BI+1:2]; tag = PC[31:BI+2].
  - pht_idx = PC[PI+1:2].
  - The same slicing applies to update_PC.
- BTB entry fields: valid (1), tag (30-BI), target (32).
- PHT entry: 2-bit counter. Prediction is taken when bit[1]=1.
- Prediction is purely combinational from PC and current table state. Latency 0; it must not depend on update in the same cycle.
  - PC==INVALID_PC: Next_PC=KEEP_EXPECTING_PC_NEXT, pred_taken=0, btb_hit=0.
  - Otherwise btb_hit = valid & (tag match).
  - btb_hit & counter[1]: Next_PC=BTB target, pred_taken=1.
  - Else: Next_PC=PC+4 (32-bit wrap, 32'hfffffffc -> 0), pred_taken=0.
- Training happens on the rising edge with update=1 and update_PC != INVALID_PC. update_PC == INVALID_PC is ignored entirely.
  - PHT[pht_idx(update_PC)]: if update_taken, increment saturating at 2'b11; else decrement saturating at 2'b00.
  - update_taken=1: write the BTB entry with valid=1, tag of update_PC, target=update_target. This overwrites any aliasing entry with a different tag.
  - update_taken=0: the BTB entry is untouched; only the counter moves.
- Write-then-read ordering:
  - A lookup in the same cycle as an update to the same index sees the pre-update contents.
  - The new contents are visible from the next cycle.
- Back-to-back updates to the same index are applied in order, one step per cycle. There is no lost or merged update.
- Reset:
  - rst=1 at an edge clears all BTB valid bits and sets every PHT counter to PHT_INIT.
  - rst dominates update in the same cycle.
  - Reset mid-stream discards all history; the first cycle after reset predicts PC+4 for every non-bubble PC.
- Output values during and after reset follow the combinational rules on the cleared state:
  - Next_PC = PC+4, or KEEP_EXPECTING_PC_NEXT for a bubble.
  - pred_taken = 0; btb_hit = 0.
- No X on any output for any PC once reset has been applied. Target storage may be left unreset, but it is gated by valid.

Test Plan:
- Reset, then PC=32'h00000100 -> Next_PC=32'h00000104, pred_taken=0, btb_hit=0. PC=32'hfafafafa -> Next_PC=32'hbfbfbfbf.
- Update PC=32'h100 taken, target 32'h200, once: counter moves 01->10. Next cycle PC=32'h100 -> btb_hit=1, pred_taken=1, Next_PC=32'h200.
- Three further taken updates on 32'h100: counter saturates at 11. Then two not-taken updates -> counter 01, Next_PC=32'h104, btb_hit still 1.
- With default BTB_ENTRIES=64, after the 32'h100->32'h200 entry is trained, a taken update on 32'h200 (same btb_idx 0, different tag) with target 32'h300 -> 32'h100 now btb_hit=0. 32'h200 predicts 32'h300 once its counter ≥10. (Note: 32'h300 shares PHT index 0 with 32'h100 only if PHT_ENTRIES=64; under default PHT_ENTRIES=256, pht_idx(32'h100)=64 and pht_idx(32'h200)=128.)
- Lookup PC=32'h100 in the same cycle as the first taken update to 32'h100 -> Next_PC=32'h104 that cycle, 32'h200 the next.
- Assert rst together with update on a trained entry -> update ignored. The following cycle predicts PC+4 everywhere. Also check PC=32'hfffffffc -> Next_PC=32'h00000000.
